// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode 7-segment driver: scans one hex digit per slot with a
// dark gap between digits, frame-latched display word, leading-zero blanking and blink.
module hex_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int SHOW_TICKS   = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              phase_q, phase_d;
  logic              first_q, first_d;
  logic [VW-1:0]     pend_q, pend_d;
  logic [VW-1:0]     act_q, act_d;
  logic [6:0]        seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic              fs_q, fs_d;

  logic              tick;
  logic [IW-1:0]     nxt_idx;
  logic [NUM_DIGITS-1:0] hi_zero;
  logic [3:0]        nib;
  logic              dark;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan sequencing; the very first BLANK after reset lands on digit 0 without counting a frame.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    idx_d   = idx_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    first_d = first_q;
    act_d   = act_q;
    fs_d    = 1'b0;
    nxt_idx = '0;
    tick    = (pre_q == PRE_LAST);
    pre_d   = tick ? '0 : pre_q + 1'b1;
    pend_d  = load ? value : pend_q;
    if (tick) begin
      case (state_q)
        ST_SHOW: begin
          if (tcnt_q == SHOW_LAST) begin
            state_d = ST_BLANK;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: begin
          nxt_idx = (first_q || idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          state_d = ST_SHOW;
          idx_d   = nxt_idx;
          first_d = 1'b0;
          if (nxt_idx == '0) begin
            fs_d  = 1'b1;
            act_d = pend_q;
            if (!first_q) begin
              if (fcnt_q == FRAME_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
              end else begin
                fcnt_d = fcnt_q + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  // hi_zero[k]: nibbles k..NUM_DIGITS-1 of the displayed word are all zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    hi_zero  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero   = all_zero & (act_q[4*k +: 4] == 4'h0);
      hi_zero[k] = all_zero;
    end
  end

  always_comb begin
    nib  = act_q[idx_q*4 +: 4];
    dark = !digit_en[idx_q]
         || (lz_suppress && (idx_q != '0) && hi_zero[idx_q])
         || (blink_mask[idx_q] && phase_q);
    seg_d = 7'h7F;
    an_d  = '1;
    if (state_q == ST_SHOW && !dark) begin
      seg_d = hex_to_seg(nib);
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BLANK;
      pre_q   <= '0;
      tcnt_q  <= '0;
      idx_q   <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
      first_q <= 1'b1;
      pend_q  <= '0;
      act_q   <= '0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      first_q <= first_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fs_q    <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule
